unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Shares one single-ported synchronous memory between the rv32i core's instruction-fetch port and its data-load/store port. Sequences every access through a small FSM: arbitrate, issue, wait the memory's fixed read latency, then return data. Sits between `rv32i_cpu` and the unified program/data RAM, so one RAM replaces separate instruction and data memories.

## Interface
Parameters:
- ADDR_WIDTH, 16, word-address width of both requesters and the memory port
- MEM_LATENCY, 1, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15, 0 is illegal

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- if_req  in  1  fetch request, level, held until `if_gnt`
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: `if_rdata` is valid
- if_rdata  out  32  fetched word, held until the next fetch response
- d_req  in  1  data request, level, held until `d_gnt`
- d_addr  in  ADDR_WIDTH  data address
- d_we  in  4  byte write mask; 0 means read
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: access complete; read data valid when `d_we` was 0
- d_rdata  out  32  load word, held until the next data read response
- mem_en  out  1  memory access strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  4  memory byte write enables
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE samples `if_req` and `d_req`. If either is high, it latches the winner as owner, along with the winner's addr, we and wdata, then moves to ISSUE. Otherwise it stays in IDLE.
- ISSUE lasts one cycle and drives:
  - the owner's gnt = 1
  - `mem_en` = 1 and `mem_addr` from the latched copy
  - `mem_we` = latched mask (fetch always uses 0) and `mem_wdata` from the latched copy
- From ISSUE, a write goes to RESP. A read loads a 4-bit counter with MEM_LATENCY-1 and goes to WAIT.
- WAIT decrements the counter. At count 0, it captures `mem_rdata` into the owner's rdata register and moves to RESP.
- RESP lasts one cycle and drives the owner's valid = 1, then returns to IDLE. A write leaves rdata unchanged.
- Arbitration on simultaneous requests: data wins (fixed priority, unless configured otherwise).
- Requester rule: deassert req, or present the next request, in the cycle after gnt. Req is only sampled in IDLE, so a held req is never granted twice within one access.
- Outside ISSUE, `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last values.
- All outputs are registered.

## Timing
- Request first seen in IDLE in cycle 0:
  - gnt and `mem_en` in cycle 1
  - read: `mem_rdata` sampled at the end of cycle 1+MEM_LATENCY, valid in cycle 2+MEM_LATENCY
  - write: valid in cycle 2
- The FSM is back in IDLE at cycle 3+MEM_LATENCY for reads and cycle 3 for writes.
- Peak throughput is one read per 3+MEM_LATENCY cycles.
- Reset (`reset` = 0 at a clk edge):
  - state IDLE, counter 0
  - every output 0, including `if_rdata` and `d_rdata`
  - round-robin last-grant = fetch
- Reset mid-access aborts the access. No gnt or valid is issued for it, and `mem_en`/`mem_we` are 0 in the following cycle.
- A requester that drops req before gnt withdraws its request. The arbiter must not issue gnt if req was low in the IDLE sample cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - on simultaneous requests, the port that did not win the last granted access wins
  - the last-grant bit updates on every ISSUE
  - a lone request always wins
- Undefined: fixed priority, data over fetch. A continuous data stream may starve fetch.

## Test plan
- MEM_LATENCY=1, fetch only, `if_addr`=0x0010, memory word 0x00A00093 -> `if_gnt` in cycle 1; `if_valid` in cycle 3 with `if_rdata`=0x00A00093; `mem_we`=0 throughout.
- MEM_LATENCY=3, data write `d_addr`=0x0020, `d_we`=4'b0011, `d_wdata`=0xDEADBEEF -> `mem_we`=4'b0011 only in cycle 1; `d_valid` in cycle 2; a later read of 0x0020 returns 0x0000BEEF (bytes 3:2 unchanged from preload 0).
- `if_req` and `d_req` both high every IDLE cycle:
  - without the macro, all grants go to data
  - with `ARB_ROUND_ROBIN_EN`, grants alternate data, fetch, data, fetch
- MEM_LATENCY=15 read -> `d_valid` exactly 17 cycles after the IDLE sample cycle; `d_rdata` stays held afterwards until the next data read.
- Reset asserted in WAIT of a fetch -> no `if_valid`; all outputs 0 after the edge; a new fetch after release completes normally.
- Back-to-back fetches, MEM_LATENCY=2, `if_req` kept high with the address advancing after each gnt -> gnt period 5 cycles; each `if_rdata` matches its own address.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported synchronous RAM between the
// rv32i fetch port and data load/store port. Every access is sequenced
// IDLE -> ISSUE -> (WAIT) -> RESP. All outputs come straight from registers.
// Optional feature: define ARB_ROUND_ROBIN_EN to replace the fixed
// data-over-fetch priority with round-robin arbitration on ties.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_we,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [31:0]           d_rdata,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_q,     state_d;
    logic [3:0]              cnt_q,       cnt_d;
    logic                    ownerData_q, ownerData_d;
    logic                    ifGnt_q,     ifGnt_d;
    logic                    dGnt_q,      dGnt_d;
    logic                    ifValid_q,   ifValid_d;
    logic                    dValid_q,    dValid_d;
    logic [31:0]             ifRdata_q,   ifRdata_d;
    logic [31:0]             dRdata_q,    dRdata_d;
    logic                    memEn_q,     memEn_d;
    logic [ADDR_WIDTH-1:0]   memAddr_q,   memAddr_d;
    logic [3:0]              memWe_q,     memWe_d;
    logic [31:0]             memWdata_q,  memWdata_d;
    logic                    pickData;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastData_q;

    // On a tie, the port that did not win the previous access goes first
    always_comb pickData = d_req && (!if_req || !lastData_q);

    // Remember which port owned the most recent issued access
    always_ff @(posedge clk) begin
        if (!reset) begin
            lastData_q <= 1'b0;
        end else if (state_q == ISSUE) begin
            lastData_q <= ownerData_q;
        end
    end
`else
    // Fixed priority: the data port wins every tie
    always_comb pickData = d_req;
`endif

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ownerData_d = ownerData_q;
        ifGnt_d     = 1'b0;
        dGnt_d      = 1'b0;
        ifValid_d   = 1'b0;
        dValid_d    = 1'b0;
        ifRdata_d   = ifRdata_q;
        dRdata_d    = dRdata_q;
        memEn_d     = 1'b0;
        memWe_d     = 4'h0;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    ownerData_d = pickData;
                    state_d     = ISSUE;
                    memEn_d     = 1'b1;
                    dGnt_d      = pickData;
                    ifGnt_d     = !pickData;
                    if (pickData) begin
                        memAddr_d  = d_addr;
                        memWe_d    = d_we;
                        memWdata_d = d_wdata;
                    end else begin
                        memAddr_d  = if_addr;
                    end
                end
            end
            ISSUE: begin
                if (memWe_q != 4'h0) begin
                    state_d   = RESP;
                    dValid_d  = ownerData_q;
                    ifValid_d = !ownerData_q;
                end else begin
                    cnt_d   = 4'(MEM_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'h0) begin
                    state_d = RESP;
                    if (ownerData_q) begin
                        dRdata_d = mem_rdata;
                        dValid_d = 1'b1;
                    end else begin
                        ifRdata_d = mem_rdata;
                        ifValid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'h0;
            ownerData_q <= 1'b0;
            ifGnt_q     <= 1'b0;
            dGnt_q      <= 1'b0;
            ifValid_q   <= 1'b0;
            dValid_q    <= 1'b0;
            ifRdata_q   <= 32'h0;
            dRdata_q    <= 32'h0;
            memEn_q     <= 1'b0;
            memAddr_q   <= '0;
            memWe_q     <= 4'h0;
            memWdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ownerData_q <= ownerData_d;
            ifGnt_q     <= ifGnt_d;
            dGnt_q      <= dGnt_d;
            ifValid_q   <= ifValid_d;
            dValid_q    <= dValid_d;
            ifRdata_q   <= ifRdata_d;
            dRdata_q    <= dRdata_d;
            memEn_q     <= memEn_d;
            memAddr_q   <= memAddr_d;
            memWe_q     <= memWe_d;
            memWdata_q  <= memWdata_d;
        end
    end

    assign if_gnt    = ifGnt_q;
    assign d_gnt     = dGnt_q;
    assign if_valid  = ifValid_q;
    assign d_valid   = dValid_q;
    assign if_rdata  = ifRdata_q;
    assign d_rdata   = dRdata_q;
    assign mem_en    = memEn_q;
    assign mem_addr  = memAddr_q;
    assign mem_we    = memWe_q;
    assign mem_wdata = memWdata_q;

endmodule
